subbytes_seq: RTL and testbench

- Parametrised multi-cycle SubBytes engine for the AES datapath.
- Captures a word of NBYTES bytes and streams it through an external S-box, LANES bytes per cycle, MSB byte first.
- Assembles the substituted word and signals completion with a one-cycle ready pulse.
- Generalises the fixed 32-bit, single-lane subbytes stage: configurable width and lane count, start/ready handshake, back-to-back operation, latched mode.

---
 rtl/subbytes_seq.sv | 155 +++++++++++++++
 tb/tb_subbytes_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/subbytes_seq.sv
// Multi-cycle SubBytes engine: streams a captured word through an external S-box, LANES bytes per cycle.
// Optional macro SUBBYTES_SEQ_SBOX_REG_EN selects a registered S-box with one-cycle return latency.
module subbytes_seq #(
  parameter int NBYTES = 4,
  parameter int LANES  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  decrypt_i,
  input  logic [8*NBYTES-1:0]   data_i,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic [8*NBYTES-1:0]   data_o,
  output logic [8*LANES-1:0]    sbox_data_o,
  input  logic [8*LANES-1:0]    sbox_data_i,
  output logic                  sbox_decrypt_o
);

  localparam int GROUPS = NBYTES / LANES;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int GW     = 8 * LANES;
  localparam int DW     = 8 * NBYTES;
  localparam logic [CW-1:0] LAST = CW'(GROUPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [DW-1:0]   work_r, work_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic            mode_r;
  logic [CW-1:0]   wr_idx_s;
  logic            wr_en_s;
  logic            last_s;
  logic            start_ok_s;

  // Group 0 (byte 0, the MSB) sits at the top of the word.
  function automatic int grp_lsb(input logic [CW-1:0] g);
    return (GROUPS - 1 - int'(g)) * GW;
  endfunction

`ifdef SUBBYTES_SEQ_SBOX_REG_EN
  logic            pend_r;
  logic [CW-1:0]   wcnt_r;

  // Write-back trails presentation by one cycle through the registered S-box.
  always_comb begin
    wr_en_s  = (state_r == RUN) && pend_r;
    wr_idx_s = wcnt_r;
    last_s   = pend_r && (wcnt_r == LAST);
  end

  // Tracks which presented group is due back from the S-box.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_r <= 1'b0;
      wcnt_r <= '0;
    end else begin
      pend_r <= (state_r == RUN) && !last_s;
      wcnt_r <= cnt_r;
    end
  end
`else
  // Combinational S-box: result written back in the same cycle it is presented.
  always_comb begin
    wr_en_s  = (state_r == RUN);
    wr_idx_s = cnt_r;
    last_s   = (cnt_r == LAST);
  end
`endif

  assign sbox_data_o    = work_r[grp_lsb(cnt_r) +: GW];
  assign sbox_decrypt_o = mode_r;
  assign start_ok_s     = start_i && ((state_r == IDLE) || (state_r == DONE));

  // Merge the S-box result into the work word.
  always_comb begin
    work_s = work_r;
    if (wr_en_s) begin
      work_s[grp_lsb(wr_idx_s) +: GW] = sbox_data_i;
    end else begin
      work_s = work_r;
    end
  end

  // Next-state and group counter.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          state_s = RUN;
          cnt_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DONE;
          cnt_s   = '0;
        end else if (cnt_r != LAST) begin
          cnt_s   = cnt_r + CW'(1);
        end else begin
          cnt_s   = cnt_r;
        end
      end
      DONE: begin
        if (start_i) begin
          state_s = RUN;
          cnt_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      work_r  <= '0;
      mode_r  <= 1'b0;
      ready_o <= 1'b0;
      busy_o  <= 1'b0;
      data_o  <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      busy_o  <= (state_s == RUN);
      ready_o <= (state_r == RUN) && last_s;
      if (start_ok_s) begin
        work_r <= data_i;
        mode_r <= decrypt_i;
      end else begin
        work_r <= work_s;
      end
      if ((state_r == RUN) && last_s) begin
        data_o <= work_s;
      end
    end
  end

endmodule

// File: tb/tb_subbytes_seq.sv
// Directed bench for subbytes_seq; bench S-box returns byte ^ 8'hFF (registered when SUBBYTES_SEQ_SBOX_REG_EN).
module tb_subbytes_seq;

`ifdef SUBBYTES_SEQ_SBOX_REG_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start4, dec4, ready4, busy4, sdec4;
  logic [31:0]  din4, dout4;
  logic [7:0]   sout4, sin4;
  logic         start16, dec16, ready16, busy16, sdec16;
  logic [127:0] din16, dout16;
  logic [15:0]  sout16, sin16;

  int pass_cnt  = 0;
  int total_cnt = 0;

  subbytes_seq #(.NBYTES(4), .LANES(1)) u_dut4 (
    .clk(clk), .reset(reset), .start_i(start4), .decrypt_i(dec4), .data_i(din4),
    .ready_o(ready4), .busy_o(busy4), .data_o(dout4),
    .sbox_data_o(sout4), .sbox_data_i(sin4), .sbox_decrypt_o(sdec4)
  );

  subbytes_seq #(.NBYTES(16), .LANES(2)) u_dut16 (
    .clk(clk), .reset(reset), .start_i(start16), .decrypt_i(dec16), .data_i(din16),
    .ready_o(ready16), .busy_o(busy16), .data_o(dout16),
    .sbox_data_o(sout16), .sbox_data_i(sin16), .sbox_decrypt_o(sdec16)
  );

`ifdef SUBBYTES_SEQ_SBOX_REG_EN
  logic [7:0]  sbox_q4;
  logic [15:0] sbox_q16;
  always_ff @(posedge clk) begin
    sbox_q4  <= ~sout4;
    sbox_q16 <= ~sout16;
  end
  assign sin4  = sbox_q4;
  assign sin16 = sbox_q16;
`else
  assign sin4  = ~sout4;
  assign sin16 = ~sout16;
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total_cnt++; if (ready4 !== 1'b0) $display("FAIL reset_ready: got %b expected 0", ready4); else pass_cnt++;
    total_cnt++; if (busy4 !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy4); else pass_cnt++;
    total_cnt++; if (dout4 !== 32'h0) $display("FAIL reset_data: got %h expected 0", dout4); else pass_cnt++;
    total_cnt++; if (sdec4 !== 1'b0) $display("FAIL reset_sdec: got %b expected 0", sdec4); else pass_cnt++;
    total_cnt++; if (sout4 !== 8'h00) $display("FAIL reset_sbox_out: got %h expected 00", sout4); else pass_cnt++;
    total_cnt++; if (dout16 !== 128'h0) $display("FAIL reset_data16: got %h expected 0", dout16); else pass_cnt++;
    total_cnt++; if (ready16 !== 1'b0) $display("FAIL reset_ready16: got %b expected 0", ready16); else pass_cnt++;
  endtask

  task automatic test_single_and_abort;
    logic [7:0] bytes_v [4];
    int idx;
    int pulses;
    bytes_v = '{8'h00, 8'h11, 8'h22, 8'h33};
    din4 = 32'h00112233; dec4 = 1'b1; start4 = 1'b1;
    tick();
    start4 = 1'b0; din4 = 32'hA5A5A5A5; dec4 = 1'b0;
    for (int c = 1; c <= 4 + EXTRA; c++) begin
      idx = (c - 1 < 3) ? c - 1 : 3;
      total_cnt++; if (busy4 !== 1'b1) $display("FAIL run_busy c%0d: got %b expected 1", c, busy4); else pass_cnt++;
      total_cnt++; if (ready4 !== 1'b0) $display("FAIL run_ready c%0d: got %b expected 0", c, ready4); else pass_cnt++;
      total_cnt++; if (sout4 !== bytes_v[idx]) $display("FAIL run_sbox_out c%0d: got %h expected %h", c, sout4, bytes_v[idx]); else pass_cnt++;
      total_cnt++; if (sdec4 !== 1'b1) $display("FAIL run_sdec c%0d: got %b expected 1", c, sdec4); else pass_cnt++;
      tick();
    end
    total_cnt++; if (ready4 !== 1'b1) $display("FAIL done_ready: got %b expected 1", ready4); else pass_cnt++;
    total_cnt++; if (busy4 !== 1'b0) $display("FAIL done_busy: got %b expected 0", busy4); else pass_cnt++;
    total_cnt++; if (dout4 !== 32'hFFEEDDCC) $display("FAIL done_data: got %h expected FFEEDDCC", dout4); else pass_cnt++;
    tick();
    total_cnt++; if (ready4 !== 1'b0) $display("FAIL pulse_width: got %b expected 0", ready4); else pass_cnt++;
    total_cnt++; if (dout4 !== 32'hFFEEDDCC) $display("FAIL data_hold: got %h expected FFEEDDCC", dout4); else pass_cnt++;
    // second run aborted by reset in cycle 3
    din4 = 32'h44556677; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total_cnt++; if (ready4 !== 1'b0) $display("FAIL abort_ready: got %b expected 0", ready4); else pass_cnt++;
    total_cnt++; if (busy4 !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy4); else pass_cnt++;
    total_cnt++; if (dout4 !== 32'h0) $display("FAIL abort_data: got %h expected 0", dout4); else pass_cnt++;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (ready4 === 1'b1) pulses++;
      tick();
    end
    total_cnt++; if (pulses !== 0) $display("FAIL abort_no_pulse: got %0d pulses expected 0", pulses); else pass_cnt++;
  endtask

  task automatic test_two_lanes;
    int runs;
    int rdy_cyc;
    din16 = 128'h000102030405060708090A0B0C0D0E0F; dec16 = 1'b0; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    total_cnt++; if (sout16 !== 16'h0001) $display("FAIL lanes_first_group: got %h expected 0001", sout16); else pass_cnt++;
    runs = 0; rdy_cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      if (ready16 === 1'b1 && rdy_cyc == 0) rdy_cyc = c;
      if (busy16 === 1'b1) runs++;
      if (c == 9 + EXTRA) begin
        total_cnt++; if (dout16 !== 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0) $display("FAIL lanes_data: got %h expected FFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0", dout16); else pass_cnt++;
      end
      tick();
    end
    total_cnt++; if (runs !== 8 + EXTRA) $display("FAIL lanes_run_cycles: got %0d expected %0d", runs, 8 + EXTRA); else pass_cnt++;
    total_cnt++; if (rdy_cyc !== 9 + EXTRA) $display("FAIL lanes_ready_cycle: got %0d expected %0d", rdy_cyc, 9 + EXTRA); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int p;
    p = 5 + EXTRA;
    din4 = 32'hDEADBEEF; dec4 = 1'b0; start4 = 1'b1;
    tick();
    din4 = 32'h0F1E2D3C; dec4 = 1'b1;
    for (int c = 1; c <= 2 * p; c++) begin
      total_cnt++; if (ready4 !== (c % p == 0)) $display("FAIL b2b_ready c%0d: got %b expected %b", c, ready4, (c % p == 0)); else pass_cnt++;
      total_cnt++; if (busy4 !== (c % p != 0)) $display("FAIL b2b_busy c%0d: got %b expected %b", c, busy4, (c % p != 0)); else pass_cnt++;
      if (c == p) begin
        total_cnt++; if (dout4 !== 32'h21524110) $display("FAIL b2b_first: got %h expected 21524110", dout4); else pass_cnt++;
      end
      if (c == p + 1) begin
        total_cnt++; if (sdec4 !== 1'b1) $display("FAIL b2b_mode: got %b expected 1", sdec4); else pass_cnt++;
      end
      if (c == 2 * p) begin
        total_cnt++; if (dout4 !== 32'hF0E1D2C3) $display("FAIL b2b_second: got %h expected F0E1D2C3", dout4); else pass_cnt++;
      end
      tick();
    end
    start4 = 1'b0;
    for (int c = 0; c < p + 2; c++) tick();
  endtask

  task automatic test_mode_latch;
    din4 = 32'h01020304; dec4 = 1'b1; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int c = 1; c <= 4 + EXTRA; c++) begin
      dec4 = ~dec4;
      #1;
      total_cnt++; if (sdec4 !== 1'b1) $display("FAIL mode_latch c%0d: got %b expected 1", c, sdec4); else pass_cnt++;
      tick();
    end
    total_cnt++; if (dout4 !== 32'hFEFDFCFB) $display("FAIL mode_data: got %h expected FEFDFCFB", dout4); else pass_cnt++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total_cnt++; if (sdec4 !== 1'b0) $display("FAIL mode_reset: got %b expected 0", sdec4); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    start4 = 1'b0; dec4 = 1'b0; din4 = 32'h0;
    start16 = 1'b0; dec16 = 1'b0; din16 = 128'h0;
    test_reset();
    test_single_and_abort();
    test_two_lanes();
    test_back_to_back();
    test_mode_latch();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
